// File: rtl/mips_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mips_lsu_pkg
// Shared types and helpers for the MIPS load/store unit.
//   lsu_op_t    : 3-bit request operation code (LB..SW)
//   lsu_state_t : control FSM states
//   is_load / is_store / is_legal_op / is_misaligned : request classification
// -----------------------------------------------------------------------------
package mips_lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_t;

  function automatic logic is_load(input lsu_op_t op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  // Every 3-bit code is assigned today; this keeps the error path meaningful
  // if the op field is ever widened.
  function automatic logic is_legal_op(input lsu_op_t op);
    return is_load(op) || is_store(op);
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      LH, LHU, SH: mis = addr_lo[0];
      LW, SW:      mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// -----------------------------------------------------------------------------
// mips_lsu_align
// Purely combinational big-endian lane logic for the load/store unit.
//   op          : operation being executed
//   addr_lo     : low two address bits (lane select)
//   rdata       : word read from the data RAM
//   wdata       : store data from the core (low byte / low half used)
//   load_result : selected byte/half/word, sign- or zero-extended
//   merged_word : rdata with the addressed byte/half replaced by wdata
//                 (for SW this is simply wdata)
// Lane 0 is the most significant byte, so the shift for byte lane k is
// (3-k)*8, and half lane addr[1]=0 lives in bits 31:16.
// -----------------------------------------------------------------------------
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_result,
  output logic [31:0] merged_word
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  // (3-k)*8 equals (~k)*8 for a 2-bit k.
  assign byte_shift = {~addr_lo, 3'b000};
  assign half_shift = {~addr_lo[1], 4'b0000};

  assign byte_val  = 8'(rdata >> byte_shift);
  assign half_val  = 16'(rdata >> half_shift);
  assign byte_mask = 32'h0000_00FF << byte_shift;
  assign half_mask = 32'h0000_FFFF << half_shift;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_result = '0;
    case (op)
      LB:      load_result = {{24{byte_val[7]}}, byte_val};
      LBU:     load_result = {24'h0, byte_val};
      LH:      load_result = {{16{half_val[15]}}, half_val};
      LHU:     load_result = {16'h0, half_val};
      LW:      load_result = rdata;
      default: load_result = '0;
    endcase
  end

  always_comb begin
    merged_word = wdata;
    case (op)
      SB:      merged_word = (rdata & ~byte_mask) | (32'(wdata[7:0])  << byte_shift);
      SH:      merged_word = (rdata & ~half_mask) | (32'(wdata[15:0]) << half_shift);
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// -----------------------------------------------------------------------------
// mips_lsu
// Load/store unit between the MIPS memory stage and a combinational-read,
// single-cycle-write data RAM without byte enables.
//   clk, reset_n        : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (accept when both high)
//   req_op/addr/wdata   : operation, byte address, store data
//   resp_valid          : one-cycle response pulse
//   resp_rdata/resp_err : extended load data (0 for stores/errors), error flag
//   data_address        : word-aligned RAM address (held between accesses)
//   data_read/write     : RAM strobes, never both high
//   data_writedata      : RAM write data
//   data_readdata       : combinational RAM read data
// Loads and SW take one RAM cycle; SB/SH read the word, merge the new lane
// and write it back. Misaligned or illegal requests answer with resp_err
// without touching the RAM.
// -----------------------------------------------------------------------------
module mips_lsu
  import mips_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] data_address_q, data_address_d;
  logic        data_read_q, data_read_d;
  logic        data_write_q, data_write_d;
  logic [31:0] data_writedata_q, data_writedata_d;

  lsu_op_t     req_op_e;
  logic        accept;
  logic [31:0] load_result;
  logic [31:0] merged_word;

  assign req_op_e = lsu_op_t'(req_op);
  assign accept   = req_valid && req_ready_q;

  mips_lsu_align u_align (
    .op          (op_q),
    .addr_lo     (addr_q[1:0]),
    .rdata       (data_readdata),
    .wdata       (wdata_q),
    .load_result (load_result),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    resp_err_d       = resp_err_q;
    resp_rdata_d     = resp_rdata_q;
    data_address_d   = data_address_q;
    data_writedata_d = data_writedata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_op_e;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!is_legal_op(req_op_e) || is_misaligned(req_op_e, req_addr[1:0])) begin
            // Straight to the response; the RAM address is left untouched.
            state_d      = ST_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            data_address_d = {req_addr[31:2], 2'b00};
            if (is_load(req_op_e)) begin
              state_d = ST_LOAD;
            end else if (req_op_e == SW) begin
              state_d          = ST_WRITE;
              data_writedata_d = req_wdata;
            end else begin
              state_d = ST_RMW_RD;
            end
          end
        end
      end

      ST_LOAD: begin
        state_d      = ST_RESP;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_result;
      end

      ST_RMW_RD: begin
        state_d          = ST_WRITE;
        data_writedata_d = merged_word;
      end

      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being
    // entered rather than the current one.
    req_ready_d  = (state_d == ST_IDLE);
    data_read_d  = (state_d == ST_LOAD) || (state_d == ST_RMW_RD);
    data_write_d = (state_d == ST_WRITE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      op_q             <= LB;
      addr_q           <= '0;
      wdata_q          <= '0;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= '0;
      data_address_q   <= '0;
      data_read_q      <= 1'b0;
      data_write_q     <= 1'b0;
      data_writedata_q <= '0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      data_address_q   <= data_address_d;
      data_read_q      <= data_read_d;
      data_write_q     <= data_write_d;
      data_writedata_q <= data_writedata_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign data_address   = data_address_q;
  assign data_read      = data_read_q;
  // Gated directly by reset so an in-flight write is dropped the moment
  // reset is asserted, not one edge later.
  assign data_write     = data_write_q & reset_n;
  assign data_writedata = data_writedata_q;

endmodule
